// File: rtl/resolution_overlay_if.sv
// Video timing, char ROM and overlay output signals of resolution_overlay.
// The slave modport is the overlay reader. The master modport is the timing generator, the ROM and the mixer.
interface resolution_overlay_if;
  logic [11:0]  hpos;
  logic [11:0]  vpos;
  logic         de;
  logic [3:0]   rom_addr;
  logic [191:0] rom_q;
  logic         overlay_active;
  logic         overlay_pixel;

  modport master (
    output hpos, vpos, de, rom_q,
    input  rom_addr, overlay_active, overlay_pixel
  );

  modport slave (
    input  hpos, vpos, de, rom_q,
    output rom_addr, overlay_active, overlay_pixel
  );
endinterface

// File: rtl/resolution_overlay.sv
// Fetches one 192-bit char ROM row per video line and serializes it into a 1-bit overlay stream.
// Optional 2x2 pixel scaling is enabled by defining RESOLUTION_OVERLAY_SCALE2X_EN.
module resolution_overlay #(
  parameter logic [15:0] X_POS = 16'd16,
  parameter logic [15:0] Y_POS = 16'd16
) (
  input logic                  clock,
  input logic                  reset,
  resolution_overlay_if.slave  bus
);

`ifdef RESOLUTION_OVERLAY_SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int          PIX   = 192 * S;
  localparam logic [16:0] WIN_H = 17'(16 * S);
  localparam logic [8:0]  LAST  = 9'(PIX - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, READY, SHIFT} state_t;

  state_t       r_state;
  logic [3:0]   r_rom_addr;
  logic [191:0] r_shift;
  logic [8:0]   r_cnt;
  logic         r_active;
  logic         r_pixel;
`ifdef RESOLUTION_OVERLAY_SCALE2X_EN
  logic         r_sub;
`endif

  logic [16:0] w_vpos;
  logic [16:0] w_ypos;
  logic [16:0] w_voff;
  logic        w_in_win;
  logic [3:0]  w_row;
  logic        w_hpos_zero;
  logic        w_at_x;
  logic        w_emit;
  logic        w_last;

  assign w_vpos      = {5'd0, bus.vpos};
  assign w_ypos      = {1'b0, Y_POS};
  assign w_voff      = w_vpos - w_ypos;
  assign w_in_win    = (w_vpos >= w_ypos) && (w_voff < WIN_H);
  assign w_row       = 4'(w_voff >> (S - 1));
  assign w_hpos_zero = (bus.hpos == 12'd0);
  assign w_at_x      = ({4'd0, bus.hpos} == X_POS);
  assign w_emit      = bus.de && ((r_state == SHIFT) || ((r_state == READY) && w_at_x));
  assign w_last      = (r_cnt == LAST);

  // Overlay FSM: a new line start takes priority, then the fetch sequence, then pixel emission.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rom_addr <= 4'd0;
      r_shift    <= 192'd0;
      r_cnt      <= 9'd0;
      r_active   <= 1'b0;
      r_pixel    <= 1'b0;
`ifdef RESOLUTION_OVERLAY_SCALE2X_EN
      r_sub      <= 1'b0;
`endif
    end else begin
      r_active <= 1'b0;
      r_pixel  <= 1'b0;
      if (w_hpos_zero) begin
        r_cnt <= 9'd0;
`ifdef RESOLUTION_OVERLAY_SCALE2X_EN
        r_sub <= 1'b0;
`endif
        if (w_in_win) begin
          r_state    <= ADDR;
          r_rom_addr <= w_row;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        case (r_state)
          IDLE:    r_state <= IDLE;
          ADDR:    r_state <= WAIT;
          WAIT:    r_state <= LOAD;
          LOAD: begin
            r_shift <= bus.rom_q;
            r_state <= READY;
          end
          READY:   r_state <= (w_at_x && bus.de) ? SHIFT : READY;
          SHIFT:   r_state <= SHIFT;
          default: r_state <= IDLE;
        endcase
        // Emission overrides the state chosen above when the last pixel leaves.
        if (w_emit) begin
          r_active <= 1'b1;
          r_pixel  <= r_shift[191];
`ifdef RESOLUTION_OVERLAY_SCALE2X_EN
          r_sub <= ~r_sub;
          if (r_sub) begin
            r_shift <= {r_shift[190:0], 1'b0};
          end
`else
          r_shift <= {r_shift[190:0], 1'b0};
`endif
          if (w_last) begin
            r_cnt   <= 9'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
      end
    end
  end

  assign bus.rom_addr       = r_rom_addr;
  assign bus.overlay_active = r_active;
  assign bus.overlay_pixel  = r_pixel;

endmodule

// File: doc/resolution_overlay.md
# resolution_overlay

Reader side of the resolution char ROM: fetches the 192-pixel-wide bitmap rows of the current resolution label and serializes them into a 1-bit overlay pixel stream aligned to the video timing. Sits between the video timing generator and the output mixer; drives the char ROM `addr` and consumes its 192-bit `q` (1-cycle registered ROM latency). One fetch per video line, prefetched ahead of the overlay window.

## Interface
- X_POS, 16: first active pixel column of the overlay; must be ≥ 4.
- Y_POS, 16: first active line of the overlay.
- clock  in  1  pixel clock; the ROM runs on the same clock.
- reset  in  1  asynchronous, active-high.
- hpos  in  12  current pixel column from the timing generator.
- vpos  in  12  current line from the timing generator.
- de  in  1  data enable; active video.
- rom_addr  out  4  row address to the char ROM.
- rom_q  in  192  ROM row data, valid 1 cycle after `rom_addr` is sampled by the ROM. Bit 191 is the leftmost pixel.
- overlay_active  out  1  pixel is inside the overlay window.
- overlay_pixel  out  1  bitmap value for that pixel; 0 when not active.

## Operation
- S = 2 if scaling is compiled in, else 1.
- Window: columns X_POS .. X_POS+192·S−1, lines Y_POS .. Y_POS+16·S−1.
- FSM states: IDLE, ADDR, WAIT, LOAD, READY, SHIFT.
- IDLE → ADDR: on a cycle with hpos==0 and vpos inside the window.
  - Register rom_addr = (vpos−Y_POS) >> (S−1), truncated to 4 bits.
- ADDR → WAIT: unconditional, 1 cycle. The ROM samples the address.
- WAIT → LOAD: unconditional. The ROM output is now valid.
- LOAD: latch rom_q into a 192-bit shift register, then go to READY.
- READY → SHIFT: on hpos==X_POS with de=1.
- SHIFT:
  - Each pixel emits shift[191]. It shifts left by 1 every S cycles, using a 1-bit sub-pixel counter when S=2.
  - A pixel counter counts 192·S cycles. At terminal count → IDLE.
- de low during SHIFT: shifting pauses and overlay_active=0. Shifting resumes when de returns.
- hpos==0 in any state other than IDLE aborts the current line.
  - If vpos is inside the window, go to ADDR; otherwise go to IDLE.
- A line outside the window never issues a fetch. rom_addr holds its last value.
- Wrap: rom_addr does not increment. It is recomputed every line, so vpos wrap needs no special handling.

## Timing
- Reset values: state IDLE, rom_addr 0, overlay_active 0, overlay_pixel 0, shift register 0, counters 0.
- Outputs are registered, with 1-cycle latency from hpos/de to overlay_active/overlay_pixel.
- The fetch completes 3 cycles after the hpos==0 edge. X_POS ≥ 4 guarantees READY before the window starts.
- Reset asserted mid-line: outputs go to 0 immediately (asynchronous). The first overlay line after release is the next hpos==0 inside the window.

## Configuration
- RESOLUTION_OVERLAY_SCALE2X_EN defined:
  - S=2. Each bitmap bit is 2×2 pixels.
  - Window is 384×32.
  - Row index = (vpos−Y_POS)>>1.
- Undefined: S=1, window 192×16, and the sub-pixel counter is not synthesized.

## Test plan
- Unscaled, row 0 = 192'h8000…0001: hpos=0, vpos=16 → rom_addr=0.
  - Active for hpos 16..207, output delayed 1 cycle.
  - overlay_pixel=1 at columns 16 and 207; 0 elsewhere.
- Line vpos=31 → rom_addr=15. Line vpos=32 → no fetch, overlay_active stays 0 for the whole line.
- de dropped for 5 cycles at hpos=100 → overlay_active=0 for those 5 cycles.
  - The pixel sequence resumes with no bits lost.
  - FSM stays in SHIFT.
- hpos forced to 0 at column 120 during SHIFT on vpos=20 → re-fetch of rom_addr=4.
  - The new line outputs from bit 191 at X_POS.
- Reset pulsed for 1 cycle at column 50 → outputs 0 on the next edge, state IDLE.
  - Overlay reappears correctly on the following line.
- With RESOLUTION_OVERLAY_SCALE2X_EN, row 0 = 192'hC000…0: pixels 16..19 = 1 and 20 = 0.
  - vpos 16 and 17 both give rom_addr=0.
  - Window ends after column 399.
